// File: rtl/flow_control_credit_pipe.sv
// Credit-based valid/ready controller around a fixed-latency, free-running operator with a result FIFO.
// Define FLOW_CTRL_BYPASS_EN to let a retiring result skip an empty FIFO and reach out_data combinationally.
module flow_control_credit_pipe #(
    parameter int LATENCY = 1,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              reset_state,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic              do_operation,
    input  logic [DATA_W-1:0] result_in,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  used
);

`ifdef FLOW_CTRL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    logic [LATENCY-1:0] r_issued;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_used;
    logic [DATA_W-1:0]  r_last;

    logic              w_in_rdy;
    logic              w_do_op;
    logic              w_retire;
    logic              w_fifo_nonempty;
    logic              w_bypass_vld;
    logic              w_out_vld;
    logic              w_pop;
    logic              w_fifo_rd;
    logic              w_fifo_wr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_out_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // Credits are reserved at issue, so a retiring result always has a free FIFO slot.
    assign w_in_rdy        = rst & en & ~flush & ~reset_state & (r_used < DEPTH_C);
    assign w_do_op         = in_vld & w_in_rdy;
    assign w_retire        = r_issued[LATENCY-1];
    assign w_fifo_nonempty = (r_occ != '0);
    assign w_bypass_vld    = BYPASS & w_retire & ~w_fifo_nonempty;
    assign w_out_vld       = w_fifo_nonempty | w_bypass_vld;
    assign w_pop           = w_out_vld & out_rdy;
    assign w_fifo_rd       = w_pop & w_fifo_nonempty;
    assign w_fifo_wr       = w_retire & ~(w_bypass_vld & out_rdy);
    assign w_mem_we        = w_fifo_wr & ~reset_state;

    // An empty FIFO keeps showing the last result handed downstream.
    assign w_out_data = w_fifo_nonempty ? r_mem[r_head] :
                        (w_bypass_vld ? result_in : r_last);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_tail] <= result_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issued <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_occ    <= '0;
            r_used   <= '0;
            r_last   <= '0;
        end else if (reset_state) begin
            r_issued <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_occ    <= '0;
            r_used   <= '0;
        end else begin
            r_issued[0] <= w_do_op;
            for (int i = 1; i < LATENCY; i++) begin
                r_issued[i] <= r_issued[i-1];
            end
            if (w_fifo_wr) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_fifo_rd) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_pop) begin
                r_last <= w_out_data;
            end
            r_occ  <= r_occ + CNT_W'(w_fifo_wr) - CNT_W'(w_fifo_rd);
            r_used <= r_used + CNT_W'(w_do_op) - CNT_W'(w_pop);
        end
    end

    assign in_rdy       = w_in_rdy;
    assign do_operation = w_do_op;
    assign out_vld      = w_out_vld;
    assign out_data     = w_out_data;
    assign busy         = (|r_issued) | w_fifo_nonempty;
    assign used         = r_used;

endmodule

// File: tb/tb_flow_control_credit_pipe.sv
// Directed bench for flow_control_credit_pipe with a scoreboard queue of issued operations.
module tb_flow_control_credit_pipe;
    localparam int LAT    = 3;
    localparam int DEPTH  = 4;
    localparam int DEPTH3 = 3;
`ifdef FLOW_CTRL_BYPASS_EN
    localparam int OUT_LAT = LAT;
`else
    localparam int OUT_LAT = LAT + 1;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        reset_state = 1'b0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic [31:0] result_in = '0;
    logic        in_rdy, do_operation, out_vld, busy;
    logic [31:0] out_data;
    logic [2:0]  used;

    logic        in_vld3 = 1'b0;
    logic        out_rdy3 = 1'b0;
    logic [31:0] result_in3 = '0;
    logic        in_rdy3, do_operation3, out_vld3, busy3;
    logic [31:0] out_data3;
    logic [1:0]  used3;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          do_cnt = 0;
    int          pop_cnt = 0;
    int          do_cnt3 = 0;
    int          pop_cnt3 = 0;
    int          first_vld_cyc = -1;
    int          n = 0;
    logic        wrap_on = 1'b0;
    logic [31:0] last_pop = '0;
    logic [31:0] nxt = '0;
    logic [31:0] nxt3 = 32'h100;
    op_t         q[$];
    op_t         q3[$];
    logic [31:0] pd [LAT];
    logic [31:0] pd3 [LAT];
    logic        pv [LAT];
    logic        pv3 [LAT];

    always #5 clk = ~clk;

    flow_control_credit_pipe #(.LATENCY(LAT), .DATA_W(32), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .reset_state(reset_state),
        .in_vld(in_vld), .in_rdy(in_rdy), .do_operation(do_operation),
        .result_in(result_in), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .busy(busy), .used(used)
    );

    flow_control_credit_pipe #(.LATENCY(LAT), .DATA_W(32), .DEPTH(DEPTH3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .reset_state(reset_state),
        .in_vld(in_vld3), .in_rdy(in_rdy3), .do_operation(do_operation3),
        .result_in(result_in3), .out_vld(out_vld3), .out_rdy(out_rdy3),
        .out_data(out_data3), .busy(busy3), .used(used3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate the current cycle against the model, advance the model, then move to the next negedge.
    task automatic step();
        logic exp_rdy, exp_do, hr, exp_rdy3, exp_do3, hr3;
        #1;
        exp_rdy = rst & en & ~flush & ~reset_state & (q.size() < DEPTH);
        exp_do  = in_vld & exp_rdy;
        hr = 1'b0;
        if (q.size() > 0) hr = (cyc >= q[0].cyc + OUT_LAT);
        chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        chk("do_operation", 64'(do_operation), 64'(exp_do));
        chk("used", 64'(used), 64'(q.size()));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("out_vld", 64'(out_vld), 64'(hr));
        if (hr) chk("out_data", 64'(out_data), 64'(q[0].data));
        chk("no_overflow", 64'(u_dut.w_fifo_wr & (u_dut.r_occ == 3'(DEPTH))), 64'(0));

        exp_rdy3 = rst & en & ~flush & ~reset_state & (q3.size() < DEPTH3);
        exp_do3  = in_vld3 & exp_rdy3;
        hr3 = 1'b0;
        if (q3.size() > 0) hr3 = (cyc >= q3[0].cyc + OUT_LAT);
        if (wrap_on) begin
            chk("wrap_in_rdy", 64'(in_rdy3), 64'(exp_rdy3));
            chk("wrap_used", 64'(used3), 64'(q3.size()));
            chk("wrap_out_vld", 64'(out_vld3), 64'(hr3));
            if (hr3) chk("wrap_out_data", 64'(out_data3), 64'(q3[0].data));
            chk("wrap_no_overflow", 64'(u_dut3.w_fifo_wr & (u_dut3.r_occ == 2'(DEPTH3))), 64'(0));
        end

        if (do_operation) do_cnt++;
        if (out_vld & out_rdy) begin
            pop_cnt++;
            last_pop = out_data;
        end
        if (out_vld & out_rdy && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (do_operation3) do_cnt3++;
        if (out_vld3 & out_rdy3) pop_cnt3++;

        if (!rst || reset_state) begin
            q.delete();
            q3.delete();
        end else begin
            if (hr && out_rdy) void'(q.pop_front());
            if (exp_do) q.push_back('{data: nxt, cyc: cyc});
            if (hr3 && out_rdy3) void'(q3.pop_front());
            if (exp_do3) q3.push_back('{data: nxt3, cyc: cyc});
        end
        for (int i = LAT - 1; i > 0; i--) begin
            pd[i] = pd[i-1];
            pv[i] = pv[i-1];
            pd3[i] = pd3[i-1];
            pv3[i] = pv3[i-1];
        end
        pd[0] = nxt;
        pv[0] = exp_do;
        pd3[0] = nxt3;
        pv3[0] = exp_do3;
        if (exp_do) nxt++;
        if (exp_do3) nxt3++;

        @(negedge clk);
        cyc++;
        result_in  = pv[LAT-1] ? pd[LAT-1] : $urandom;
        result_in3 = pv3[LAT-1] ? pd3[LAT-1] : $urandom;
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pd[i] = '0; pv[i] = 1'b0; pd3[i] = '0; pv3[i] = 1'b0;
        end
        en = 1'b1;
        in_vld = 1'b1;
        out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_used", 64'(used), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_do_operation", 64'(do_operation), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        in_vld = 1'b0;
        cyc = 0;

        // single operation issued in cycle 10
        while (cyc < 10) step();
        in_vld = 1'b1;
        nxt = 32'hA5;
        step();
        in_vld = 1'b0;
        while (cyc < 16) step();
        chk("single_latency", 64'(first_vld_cyc), 64'(10 + OUT_LAT));
        chk("single_pops", 64'(pop_cnt), 64'(1));
        chk("single_data", 64'(last_pop), 64'(32'hA5));
        chk("single_busy", 64'(busy), 64'(0));

        // backpressure: credits run out at DEPTH
        out_rdy = 1'b0;
        in_vld = 1'b1;
        nxt = 32'd1;
        do_cnt = 0;
        repeat (10) step();
        chk("bp_issues", 64'(do_cnt), 64'(4));
        chk("bp_used", 64'(used), 64'(4));
        chk("bp_in_rdy", 64'(in_rdy), 64'(0));
        in_vld = 1'b0;
        out_rdy = 1'b1;
        pop_cnt = 0;
        step();
        chk("bp_rdy_return", 64'(in_rdy), 64'(1));
        repeat (7) step();
        chk("bp_pops", 64'(pop_cnt), 64'(4));
        chk("bp_last", 64'(last_pop), 64'(4));

        // streaming 20 operations
        do_cnt = 0;
        n = 0;
        in_vld = 1'b1;
        while (do_cnt < 20 && n < 80) begin
            step();
            n++;
        end
        in_vld = 1'b0;
        chk("stream_issues", 64'(do_cnt), 64'(20));
`ifdef FLOW_CTRL_BYPASS_EN
        chk("stream_cycles", 64'(n), 64'(20));
`endif
        repeat (8) step();
        chk("stream_drained", 64'(busy), 64'(0));

        // pointer wrap on the 3-deep instance with random backpressure
        wrap_on = 1'b1;
        do_cnt3 = 0;
        pop_cnt3 = 0;
        n = 0;
        while ((do_cnt3 < 10 || q3.size() != 0) && n < 300) begin
            in_vld3 = (do_cnt3 < 10);
            out_rdy3 = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        in_vld3 = 1'b0;
        wrap_on = 1'b0;
        chk("wrap_issues", 64'(do_cnt3), 64'(10));
        chk("wrap_pops", 64'(pop_cnt3), 64'(10));
        chk("wrap_busy", 64'(busy3), 64'(0));

        // flush with two operations in flight
        in_vld = 1'b1;
        out_rdy = 1'b1;
        do_cnt = 0;
        pop_cnt = 0;
        repeat (2) step();
        flush = 1'b1;
        #1;
        chk("flush_in_rdy", 64'(in_rdy), 64'(0));
        repeat (8) step();
        chk("flush_issues", 64'(do_cnt), 64'(2));
        chk("flush_pops", 64'(pop_cnt), 64'(2));
        chk("flush_busy", 64'(busy), 64'(0));
        flush = 1'b0;
        in_vld = 1'b0;
        step();

        // reset_state with two buffered and two in flight
        in_vld = 1'b1;
        out_rdy = 1'b0;
        repeat (5) step();
        in_vld = 1'b0;
        chk("rs_used_before", 64'(used), 64'(4));
        chk("rs_occ_before", 64'(u_dut.r_occ), 64'(2));
        reset_state = 1'b1;
        step();
        reset_state = 1'b0;
        chk("rs_out_vld", 64'(out_vld), 64'(0));
        chk("rs_used", 64'(used), 64'(0));
        chk("rs_busy", 64'(busy), 64'(0));
        out_rdy = 1'b1;
        pop_cnt = 0;
        repeat (6) step();
        chk("rs_no_output", 64'(pop_cnt), 64'(0));

        // asynchronous reset mid-stream
        in_vld = 1'b1;
        out_rdy = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        #1;
        chk("arst_out_vld", 64'(out_vld), 64'(0));
        chk("arst_used", 64'(used), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_in_rdy", 64'(in_rdy), 64'(0));
        chk("arst_do_operation", 64'(do_operation), 64'(0));
        chk("arst_out_data", 64'(out_data), 64'(0));
        q.delete();
        step();
        rst = 1'b1;
        in_vld = 1'b0;
        pop_cnt = 0;
        repeat (6) step();
        chk("arst_no_output", 64'(pop_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
